// File: rtl/lojik_pkg.sv
// lojik_pkg: shared FSM state encoding and default operand width for the shift-add multiplier.
package lojik_pkg;
    localparam int WIDTH_DEF = 4;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/ripple_adder_n.sv
// ripple_adder_n: N-bit ripple-carry adder built from a chain of full_adder cells.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module ripple_adder_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);
    logic [N:0] c;
    assign c[0]  = c_in;
    assign c_out = c[N];
    for (genvar i = 0; i < N; i++) begin : g_fa
        full_adder u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (c[i]),
            .sum   (sum[i]),
            .c_out (c[i+1])
        );
    end
endmodule

// File: rtl/shift_add_mult4.sv
// shift_add_mult4: sequential unsigned shift-and-add multiplier with valid/ready handshakes.
// Define MULT_EARLY_EXIT_EN to leave BUSY as soon as no multiplier bits remain.
module shift_add_mult4
    import lojik_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH + 1);

    state_e               state_q;
    logic [2*WIDTH-1:0]   mcand_q, acc_q, acc_d, sum;
    logic [WIDTH-1:0]     mplier_q;
    logic [CW-1:0]        cnt_q;
    logic                 last;
    logic                 add_c_out_unused;

    ripple_adder_n #(.N(2 * WIDTH)) u_add (
        .a     (acc_q),
        .b     (mcand_q),
        .c_in  (1'b0),
        .sum   (sum),
        .c_out (add_c_out_unused)
    );

    assign acc_d = mplier_q[0] ? sum : acc_q;
`ifdef MULT_EARLY_EXIT_EN
    assign last = (cnt_q == CW'(WIDTH - 1)) || ((mplier_q >> 1) == '0);
`else
    assign last = cnt_q == CW'(WIDTH - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid && in_ready) begin
                    mcand_q  <= {{WIDTH{1'b0}}, a};
                    mplier_q <= b;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    in_ready <= 1'b0;
                    state_q  <= S_BUSY;
                end
                S_BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last) begin
                        state_q   <= S_DONE;
                        out_valid <= 1'b1;
                        product   <= acc_d;
                    end
                end
                S_DONE: if (out_ready) begin
                    state_q   <= S_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: begin
                    state_q   <= S_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule
